// File: rtl/led_matrix_pkg.sv
// -----------------------------------------------------------------------------
// led_matrix_pkg
// Shared types and helpers for the LED matrix panel datapath.
//   scan_state_t : states of the row-scan controller
//   cnt_width()  : width of a counter that must hold 0..n-1 (never below 1 bit)
// -----------------------------------------------------------------------------
package led_matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_SHIFT_HI = 3'd4,
        ST_LATCH    = 3'd5,
        ST_DISPLAY  = 3'd6
    } scan_state_t;

    localparam int DEFAULT_NUM_ROWS = 16;
    localparam int DEFAULT_ROW_BITS = $clog2(DEFAULT_NUM_ROWS);

    // A terminal count of 0 (n == 1) still needs one storage bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_scan_ctrl_flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
// Up-counter with synchronous clear and programmable rollover value.
//   clk, rst       : system clock, synchronous active-high reset
//   clear          : force count to 0 (wins over count_enable)
//   count_enable   : advance by one; wraps to 0 after rollover_val
//   rollover_val   : terminal count
//   count_out      : current count
//   rollover_flag  : high while count_out == rollover_val
// -----------------------------------------------------------------------------
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = '0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// -----------------------------------------------------------------------------
// matrix_scan_ctrl
// Row-scan controller for the LED matrix panel. Fetches one row from the frame
// buffer, loads it into the column shifter, clocks it out bit by bit on
// panel_clk, latches it and lights the row for OE_CYCLES cycles.
//   clk, rst          : system clock, synchronous active-high reset
//   enable            : run the scan (checked in IDLE and at end of DISPLAY)
//   mem_rd_en/addr    : frame-buffer read strobe and row address
//   mem_rdata         : row data, valid the cycle after mem_rd_en
//   sr_load_enable    : column shifter parallel load
//   sr_shift_enable   : column shifter shift strobe
//   sr_parallel_in    : column shifter parallel data (mem_rdata passthrough)
//   panel_clk/lat/oe_n: panel column clock, latch strobe, active-low enable
//   panel_row         : displayed row address (changes only while blanked)
//   frame_done        : one-cycle pulse at the end of the last row's DISPLAY
// -----------------------------------------------------------------------------
module matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int NUM_COLS  = 64,
    parameter int NUM_ROWS  = DEFAULT_NUM_ROWS,
    parameter int ROW_BITS  = $clog2(NUM_ROWS),
    parameter int CLK_DIV   = 2,
    parameter int OE_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic                mem_rd_en,
    output logic [ROW_BITS-1:0] mem_addr,
    input  logic [NUM_COLS-1:0] mem_rdata,
    output logic                sr_load_enable,
    output logic                sr_shift_enable,
    output logic [NUM_COLS-1:0] sr_parallel_in,
    output logic                panel_clk,
    output logic                panel_lat,
    output logic                panel_oe_n,
    output logic [ROW_BITS-1:0] panel_row,
    output logic                frame_done
);

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int BIT_W = cnt_width(NUM_COLS);
    localparam int OE_W  = cnt_width(OE_CYCLES);

    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(NUM_COLS - 1);
    localparam logic [OE_W-1:0]     OE_LAST  = OE_W'(OE_CYCLES - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(NUM_ROWS - 1);

    scan_state_t         state_q, state_d;
    logic [ROW_BITS-1:0] row_cnt_q, row_cnt_d;
    logic [ROW_BITS-1:0] panel_row_q, panel_row_d;

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [OE_W-1:0]  oe_cnt;
    logic             div_last, bit_last, oe_last;

    logic in_shift, in_load, in_display;

    assign in_shift   = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
    assign in_load    = (state_q == ST_LOAD);
    assign in_display = (state_q == ST_DISPLAY);

    // div_cnt wraps naturally at each half-period, so it needs no clear
    // between SHIFT_LO and SHIFT_HI; LOAD gives every row a clean start.
    flex_counter #(.WIDTH(DIV_W)) u_div_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (in_load),
        .count_enable  (in_shift),
        .rollover_val  (DIV_LAST),
        .count_out     (div_cnt),
        .rollover_flag (div_last)
    );

    flex_counter #(.WIDTH(BIT_W)) u_bit_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (in_load),
        .count_enable  ((state_q == ST_SHIFT_HI) && div_last),
        .rollover_val  (BIT_LAST),
        .count_out     (bit_cnt),
        .rollover_flag (bit_last)
    );

    flex_counter #(.WIDTH(OE_W)) u_oe_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (!in_display),
        .count_enable  (in_display),
        .rollover_val  (OE_LAST),
        .count_out     (oe_cnt),
        .rollover_flag (oe_last)
    );

    // Raw counts are only consumed through the rollover flags; keep them as
    // named nets for waveform debug.
    logic unused_cnt_bits;
    assign unused_cnt_bits = ^{div_cnt, bit_cnt, oe_cnt};

    always_comb begin
        state_d         = state_q;
        row_cnt_d       = row_cnt_q;
        panel_row_d     = panel_row_q;
        mem_rd_en       = 1'b0;
        sr_load_enable  = 1'b0;
        sr_shift_enable = 1'b0;
        panel_clk       = 1'b0;
        panel_lat       = 1'b0;
        panel_oe_n      = 1'b1;
        frame_done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_rd_en = 1'b1;
                state_d   = ST_LOAD;
            end
            ST_LOAD: begin
                sr_load_enable = 1'b1;
                state_d        = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (div_last) begin
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                panel_clk = 1'b1;
                // Shift only after the panel has seen the rising edge, so the
                // next bit settles during the following low half-period.
                if (div_last) begin
                    sr_shift_enable = 1'b1;
                    state_d         = bit_last ? ST_LATCH : ST_SHIFT_LO;
                end
            end
            ST_LATCH: begin
                panel_lat   = 1'b1;
                panel_row_d = row_cnt_q;
                state_d     = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                panel_oe_n = 1'b0;
                if (oe_last) begin
                    frame_done = (row_cnt_q == ROW_LAST);
                    row_cnt_d  = (row_cnt_q == ROW_LAST) ? '0
                                                         : row_cnt_q + ROW_BITS'(1);
                    state_d    = enable ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_cnt_q   <= '0;
            panel_row_q <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            panel_row_q <= panel_row_d;
        end
    end

    assign mem_addr       = row_cnt_q;
    assign sr_parallel_in = mem_rdata;
    assign panel_row      = panel_row_q;

endmodule
